// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, zero-register constant and writeback entry type.
package writeback_unit_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RAW = 5;
  typedef logic [RAW-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = '0;
  typedef struct packed {
    reg_addr_t rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: ALU/LSU result, issue, register-file write, scoreboard and bypass signals.
interface writeback_unit_if #(parameter int XLEN = 32, parameter int NREG = 32);
  logic alu_valid;
  logic [4:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic lsu_valid;
  logic lsu_ready;
  logic [4:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic issue_valid;
  logic [4:0] issue_rd;
  logic rf_write;
  logic [4:0] rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic [NREG-1:0] busy;
  logic byp_valid;
  logic [4:0] byp_addr;
  logic [XLEN-1:0] byp_data;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd,
    input lsu_ready, rf_write, rf_rd_addr, rf_rd_data, busy, byp_valid, byp_addr, byp_data
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd,
    output lsu_ready, rf_write, rf_rd_addr, rf_rd_data, busy, byp_valid, byp_addr, byp_data
  );
endinterface

// File: rtl/writeback_unit_fifo.sv
// wb_result_fifo: synchronous FIFO of writeback entries with occupancy count.
module wb_result_fifo import writeback_unit_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic [CW-1:0] count
);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU/LSU results onto the register-file write port with a busy scoreboard.
// Optional bypass registers are built when WRITEBACK_BYPASS_EN is defined.
module writeback_unit import writeback_unit_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  writeback_unit_if.slave bus
);
  localparam int CW = $clog2(LSU_FIFO_DEPTH + 1);
  logic alu_sel, lsu_acc, empty, push, pop, wr;
  logic [CW-1:0] count;
  wb_entry_t head, sel;
  logic [NREG-1:0] busy_nx;
  // Ready comes from the registered count only, so a push alongside a pop at full never overflows.
  assign bus.lsu_ready = count < CW'(LSU_FIFO_DEPTH);
  assign empty = count == '0;
  assign alu_sel = bus.alu_valid && bus.alu_rd != ZERO_REG;
  assign lsu_acc = bus.lsu_valid && bus.lsu_ready && bus.lsu_rd != ZERO_REG;
  assign pop = !alu_sel && !empty;
  assign push = lsu_acc && (alu_sel || !empty);
  assign wr = alu_sel || !empty || lsu_acc;
  always_comb
    sel = alu_sel ? wb_entry_t'{rd: bus.alu_rd, data: bus.alu_data}
        : !empty ? head : wb_entry_t'{rd: bus.lsu_rd, data: bus.lsu_data};
  wb_result_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(wb_entry_t'{rd: bus.lsu_rd, data: bus.lsu_data}), .dout(head), .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rf_write <= 1'b0;
      bus.rf_rd_addr <= '0;
      bus.rf_rd_data <= '0;
    end else begin
      bus.rf_write <= wr;
      if (wr) begin
        bus.rf_rd_addr <= sel.rd;
        bus.rf_rd_data <= sel.data;
      end
    end
  always_comb begin
    busy_nx = bus.busy;
    if (bus.rf_write) busy_nx[bus.rf_rd_addr] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != ZERO_REG) busy_nx[bus.issue_rd] = 1'b1;
    busy_nx[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.busy <= '0;
    else bus.busy <= busy_nx;
`ifdef WRITEBACK_BYPASS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.byp_valid <= 1'b0;
      bus.byp_addr <= '0;
      bus.byp_data <= '0;
    end else begin
      bus.byp_valid <= bus.rf_write;
      bus.byp_addr <= bus.rf_rd_addr;
      bus.byp_data <= bus.rf_rd_data;
    end
`else
  assign bus.byp_valid = 1'b0;
  assign bus.byp_addr = '0;
  assign bus.byp_data = '0;
`endif
  // Re-issuing to a register on its own commit edge is legal: the write retires as the new one issues.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.issue_valid && bus.issue_rd != ZERO_REG && bus.busy[bus.issue_rd] &&
      !(bus.rf_write && bus.rf_rd_addr == bus.issue_rd)))
    else $error("issue to busy destination register");
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized and directed checks of writeback_unit against a queue-based model.
module tb_writeback_unit;
  import writeback_unit_pkg::*;
  localparam int D = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  writeback_unit_if #(.XLEN(32), .NREG(32)) bus();
  writeback_unit #(.XLEN(32), .NREG(32), .LSU_FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  wb_entry_t q[$];
  logic exp_w, exp_bv;
  logic [4:0] exp_a, exp_ba;
  logic [31:0] exp_d, exp_bd, exp_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("rf_write", bus.rf_write, exp_w);
    if (exp_w) begin
      check("rf_rd_addr", bus.rf_rd_addr, exp_a);
      check("rf_rd_data", bus.rf_rd_data, exp_d);
    end
    check("busy", bus.busy, exp_busy);
    check("lsu_ready", bus.lsu_ready, q.size() < D);
`ifdef WRITEBACK_BYPASS_EN
    check("byp_valid", bus.byp_valid, exp_bv);
    if (exp_bv) begin
      check("byp_addr", bus.byp_addr, exp_ba);
      check("byp_data", bus.byp_data, exp_bd);
    end
`else
    check("byp_valid", bus.byp_valid, 0);
    check("byp_addr", bus.byp_addr, 0);
    check("byp_data", bus.byp_data, 0);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    exp_w = 0; exp_a = 0; exp_d = 0; exp_busy = 0;
    exp_bv = 0; exp_ba = 0; exp_bd = 0;
  endtask

  // One clock: drive inputs, advance the model, then check at the next falling edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird);
    logic [31:0] nb;
    wb_entry_t e;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
    bus.issue_valid = iv; bus.issue_rd = ird;
    if (lv && q.size() < D && lrd != 0) q.push_back(wb_entry_t'{rd: lrd, data: ld});
    nb = exp_busy;
    if (exp_w) nb[exp_a] = 1'b0;
    if (iv && ird != 0) nb[ird] = 1'b1;
    exp_bv = exp_w; exp_ba = exp_a; exp_bd = exp_d;
    if (av && ard != 0) begin
      exp_w = 1; exp_a = ard; exp_d = ad;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_w = 1; exp_a = e.rd; exp_d = e.data;
    end else exp_w = 0;
    exp_busy = nb;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic ok_issue(input logic [4:0] r);
    return !exp_busy[r] || (exp_w && exp_a == r);
  endfunction

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0);
    check("tp1_write", bus.rf_write, 1);
    check("tp1_addr", bus.rf_rd_addr, 5);
    check("tp1_data", bus.rf_rd_data, 32'h1234_5678);
    check("tp1_busy_held", bus.busy[5], 1);
    idle();
    check("tp1_busy_clr", bus.busy[5], 0);
    step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
    check("tp2_first", bus.rf_rd_addr, 3);
    check("tp2_ready", bus.lsu_ready, 1);
    idle();
    check("tp2_second", bus.rf_rd_addr, 4);
    check("tp2_data", bus.rf_rd_data, 32'hB);
    idle();
    for (int i = 0; i < 4; i++) begin
      check("tp3_ready", bus.lsu_ready, i < 2);
      step(1, 5'(8 + i), 32'(i), 1, 5'(16 + i), 32'(256 + i), 0, 0);
    end
    idle();
    check("tp3_drain0", bus.rf_rd_addr, 16);
    idle();
    check("tp3_drain1", bus.rf_rd_data, 257);
    idle();
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    check("tp4_nowrite", bus.rf_write, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(1, 10, 32'h10, 1, 20, 32'h20, 1, 6);
    step(1, 11, 32'h11, 1, 21, 32'h21, 1, 7);
    check("tp6_full", bus.lsu_ready, 0);
    check("tp6_busy", bus.busy, 32'h0000_00F0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.lsu_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("rst_nowrite", bus.rf_write, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 7, 32'h77, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7);
    check("tp5_busy7", bus.busy[7], 1);
    for (int n = 0; n < 3000; n++) begin
      logic av, lv, iv;
      logic [4:0] ard, lrd, ird;
      av = $urandom_range(0, 2) == 0;
      lv = $urandom_range(0, 1) == 1;
      ard = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
      ird = 5'($urandom_range(0, 31));
      iv = $urandom_range(0, 1) == 1 && ok_issue(ird);
      step(av, ard, $urandom, lv, lrd, $urandom, iv, ird);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Register-file write-side controller for the integer pipeline. It collects results from the single-cycle ALU and the multi-cycle load/store unit (LSU), arbitrates them onto the register file's single write port, and tracks pending destination registers in a scoreboard for hazard detection by the issue stage. It also provides a one-entry bypass so readers can recover a value committed on the same edge their registered read was launched.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers (register 0 hardwired zero)
- LSU_FIFO_DEPTH, 2, LSU result skid entries (power of two, >= 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  LSU result accepted when valid&ready
- lsu_rd  in  5  LSU destination
- lsu_data  in  XLEN  load data
- issue_valid  in  1  instruction issued with a destination
- issue_rd  in  5  destination to mark pending
- rf_write  out  1  register-file write enable
- rf_rd_addr  out  5  register-file write address
- rf_rd_data  out  XLEN  register-file write data
- busy  out  NREG  pending-write bit per register
- byp_valid  out  1  bypass entry valid
- byp_addr  out  5  register committed at last edge
- byp_data  out  XLEN  value committed at last edge

## Operation
- Reset: rf_write=0, rf_rd_addr=0, rf_rd_data=0, busy=0, FIFO empty, lsu_ready=1 after reset release, byp_valid=0, byp_addr=0, byp_data=0.
- Results with rd=0 are accepted and discarded: no write, no scoreboard change, no FIFO push.
- Arbitration each cycle, one write selected, priority order:
  1. alu_valid (rd!=0): ALU writes; any accepted LSU result is pushed to FIFO.
  2. FIFO non-empty: pop head; any accepted LSU result is pushed (simultaneous push/pop at full is permitted only because lsu_ready reflects registered count).
  3. LSU accepted, FIFO empty: LSU result written directly, no push.
- lsu_ready = (FIFO count < LSU_FIFO_DEPTH), from registered count; combinational only on state, never on lsu_valid.
- Selected write registered into rf_write/rf_rd_addr/rf_rd_data; register file commits on the following edge.
- Scoreboard: issue_valid & issue_rd!=0 sets busy[issue_rd]; commit edge of rf_write clears busy[rf_rd_addr]. Same register set and cleared on one edge: set wins. busy[0] constantly 0.
- Issue stage never issues to a busy rd (WAW rule); simulation assertion flags violation. LSU results for one register are never reordered (FIFO order).

## Timing
- ALU result at cycle N: rf_write high in cycle N+1, register updated at end of N+1, busy bit low from cycle N+2.
- LSU direct path: same latency as ALU. Via FIFO: one extra cycle per queued entry ahead and per competing ALU cycle.
- Bypass (when compiled in): byp_* registered copy of rf_* from previous cycle; byp_valid high exactly the cycle after rf_write, valid for one cycle.
- Reset asserted mid-operation: all FIFO contents, pending writes and busy bits dropped immediately; no write issued after release until new input.

## Configuration
- WRITEBACK_BYPASS_EN defined: bypass registers present, byp_* behave as above.
- Not defined: byp_valid, byp_addr, byp_data tied 0; no bypass registers.

## Structure
- Shared package: XLEN, NREG, register-address width (5), ZERO_REG constant, struct/typedef for a writeback entry {rd, data}.
- One sub-module: wb_result_fifo (synchronous FIFO of writeback entries, count output, push/pop, async active-low reset).

## Test plan
- ALU rd=5 data 0x1234_5678 at cycle 1 -> rf_write=1, addr 5, data 0x1234_5678 in cycle 2; busy[5] (set by issue cycle 0) low from cycle 3.
- ALU and LSU valid same cycle (rd 3 / rd 4, 0xA / 0xB) -> rd 3 written cycle N+1, rd 4 cycle N+2; lsu_ready stays 1.
- ALU valid 4 consecutive cycles with LSU offering each cycle -> FIFO fills to 2, lsu_ready low from third cycle; LSU entries drain in order after ALU stops.
- ALU rd=0 data 0xFFFF_FFFF -> rf_write stays 0, busy unchanged.
- issue_rd=7 on same edge as commit of rd 7 -> busy[7]=1 after edge.
- Reset pulsed with 2 FIFO entries and busy=0x0000_00F0 -> busy=0, lsu_ready=1, no rf_write after release; with WRITEBACK_BYPASS_EN, byp_valid=0.
